spi_bus_arbiter: RTL and testbench

- Shares one spi_master instance between NUM_REQ requesters, one full-duplex DATA_WIDTH-bit transfer per grant.
- Round-robin arbitration; the arbiter loads tx_data into the master, restarts the master, waits for tx_done and rx_done, then returns rx_data to the granted requester.
- Sits between client logic (register banks, sensor pollers) and spi_master; spi_master's ports are untouched.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_bus_arbiter_if.sv | 29 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/spi_bus_arbiter.sv | 165 ++++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI bus arbiter: FSM state encoding,
// default transfer width and the all-ones response word.
package spi_pkg;

    localparam int SPI_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        SETTLE = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } arb_state_t;

    localparam logic [SPI_DATA_WIDTH-1:0] ALL_ONES = '1;

endpackage

// File: rtl/spi_bus_arbiter_if.sv
// Requester-side and spi_master-side signals of the SPI bus arbiter.
// master: the environment (requesters + spi_master); slave: the arbiter.
interface spi_bus_arbiter_if
    import spi_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = SPI_DATA_WIDTH
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            done;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic                          m_reset;
    logic [DATA_WIDTH-1:0]         m_tx_data;
    logic                          m_tx_done;
    logic                          m_rx_done;
    logic [DATA_WIDTH-1:0]         m_rx_data;

    modport master (
        output req, req_data, m_tx_done, m_rx_done, m_rx_data,
        input  gnt, done, rsp_data, m_reset, m_tx_data
    );

    modport slave (
        input  req, req_data, m_tx_done, m_rx_done, m_rx_data,
        output gnt, done, rsp_data, m_reset, m_tx_data
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request bit above `last`,
// wrapping modulo NUM_REQ. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);
    int cand;

    // scan upward from last+1 and keep the first requester found
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last) + k) % NUM_REQ;
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IDX_W'(cand);
            end
        end
    end
endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin sharing of one spi_master between NUM_REQ requesters.
// Optional watchdog on the WAIT state: define SPI_ARB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no transfer; pick next requester, latch its tx word
// START  | m_reset low for one cycle, restarts the master
// SETTLE | m_reset high again; done inputs still stale, ignored
// WAIT   | wait for tx_done and rx_done together
// DONE   | done pulse, rsp_data valid, pointer advanced
module spi_bus_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = SPI_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 8192
) (
    input  logic             clk,
    input  logic             reset,
    spi_bus_arbiter_if.slave bus,
    output logic             busy,
    output logic             timeout
);
    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t            state_q, state_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [NUM_REQ-1:0]    done_q, done_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [IDX_W-1:0]      last_q, last_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [DATA_WIDTH-1:0] m_tx_data_q, m_tx_data_d;
    logic                  m_reset_q, m_reset_d;
    logic                  busy_q, busy_d;

    logic [NUM_REQ-1:0]    arb_gnt;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_any;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req  (bus.req),
        .last (last_q),
        .gnt  (arb_gnt),
        .idx  (arb_idx),
        .any  (arb_any)
    );

    // next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        idx_d       = idx_q;
        last_d      = last_q;
        done_d      = '0;
        rsp_data_d  = rsp_data_q;
        m_tx_data_d = m_tx_data_q;
        m_reset_d   = 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    gnt_d       = arb_gnt;
                    idx_d       = arb_idx;
                    m_tx_data_d = bus.req_data[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
                    m_reset_d   = 1'b0;
                    state_d     = START;
                end
            end
            START: begin
                state_d = SETTLE;
            end
            SETTLE: begin
                state_d = WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (bus.m_tx_done && bus.m_rx_done) begin
                    rsp_data_d = bus.m_rx_data;
                    done_d     = gnt_q;
                    state_d    = DONE;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d  = 1'b1;
                    done_d     = gnt_q;
                    rsp_data_d = '1;
                    last_d     = idx_q;
                    gnt_d      = '0;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                last_d  = idx_q;
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // state and output registers; m_reset follows the arbiter reset low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            done_q      <= '0;
            idx_q       <= '0;
            last_q      <= IDX_W'(NUM_REQ - 1);
            rsp_data_q  <= '0;
            m_tx_data_q <= '0;
            m_reset_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            rsp_data_q  <= rsp_data_d;
            m_tx_data_q <= m_tx_data_d;
            m_reset_q   <= m_reset_d;
            busy_q      <= busy_d;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    // watchdog counter and timeout pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.m_reset   = m_reset_q;
    assign bus.m_tx_data = m_tx_data_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: behavioural spi_master stand-in plus a
// round-robin reference model; directed scenarios and a random run.
module tb_spi_bus_arbiter;
    localparam int N = 4;
    localparam int W = 8;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TO_CYC = 64;
`else
    localparam int TO_CYC = 8192;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic busy;
    logic timeout;

    spi_bus_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(W)) bus ();

    spi_bus_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int model_last = N - 1;
    int n_done_pulses = 0;
    int n_to_pulses   = 0;

    // spi_master stand-in
    int         lat_tx = 4;
    int         lat_rx = 6;
    int         mcnt   = 0;
    bit         force_tx_low = 1'b0;
    logic [W-1:0] slave_reply = '0;
    logic [W-1:0] slave_rx_q[$];

    always @(posedge clk) begin
        if (bus.m_reset !== 1'b1) begin
            bus.m_tx_done <= 1'b0;
            bus.m_rx_done <= 1'b0;
            mcnt          <= 0;
            if (reset) slave_rx_q.push_back(bus.m_tx_data);
        end else begin
            mcnt <= mcnt + 1;
            if (mcnt + 1 == lat_tx && !force_tx_low) bus.m_tx_done <= 1'b1;
            if (mcnt + 1 == lat_rx) begin
                bus.m_rx_done <= 1'b1;
                bus.m_rx_data <= slave_reply;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.done != '0) n_done_pulses++;
        if (timeout === 1'b1) n_to_pulses++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // reference round-robin: first pending requester after the last served one
    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic do_reset();
        bus.req   = '0;
        force_tx_low = 1'b0;
        reset     = 1'b0;
        repeat (3) @(negedge clk);
        reset     = 1'b1;
        repeat (3) @(negedge clk);
        slave_rx_q.delete();
        model_last = N - 1;
    endtask

    // one full transfer; requests must already be set up by the caller
    task automatic xfer(input int exp_idx, input logic [W-1:0] exp_tx, input logic [W-1:0] reply,
                        input bit release_req, input bit mutate, input bit check_latency);
        int t;
        bit seen;
        slave_reply = reply;
        lat_tx = $urandom_range(1, 12);
        lat_rx = $urandom_range(1, 12);
        seen = 1'b0;
        for (t = 0; t < 64 && !seen; t++) begin
            @(negedge clk);
            if (bus.gnt != '0) seen = 1'b1;
        end
        chk("grant_seen", 32'(seen), 1);
        if (check_latency) chk("grant_latency", t, 1);
        chk("gnt", 32'(bus.gnt), 32'(1) << exp_idx);
        chk("busy_in_xfer", 32'(busy), 1);
        if (mutate) begin
            bus.req[exp_idx] = 1'b0;
            bus.req_data[exp_idx*W +: W] = '0;
        end
        seen = 1'b0;
        for (t = 0; t < 200 && !seen; t++) begin
            @(negedge clk);
            if (bus.done != '0) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 1);
        chk("done_onehot", 32'(bus.done), 32'(1) << exp_idx);
        chk("gnt_at_done", 32'(bus.gnt), 32'(1) << exp_idx);
        chk("rsp_data", 32'(bus.rsp_data), 32'(reply));
        if (slave_rx_q.size() == 1) chk("slave_rx_word", 32'(slave_rx_q.pop_front()), 32'(exp_tx));
        else chk("slave_rx_count", slave_rx_q.size(), 1);
        if (release_req) bus.req[exp_idx] = 1'b0;
        model_last = exp_idx;
        @(negedge clk);
        chk("done_one_cycle", 32'(bus.done), 0);
        chk("gnt_dropped", 32'(bus.gnt), 0);
        chk("busy_after", 32'(busy), 0);
        chk("rsp_held", 32'(bus.rsp_data), 32'(reply));
    endtask

    initial begin
        int idx;
        int p0;
        int t;
        bit seen;
        logic [N-1:0] mask;
        logic [N-1:0] newbits;

        bus.req      = '0;
        bus.req_data = '0;

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_rsp", 32'(bus.rsp_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_m_reset", 32'(bus.m_reset), 0);
        chk("rst_m_tx", 32'(bus.m_tx_data), 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("m_reset_released", 32'(bus.m_reset), 1);
        slave_rx_q.delete();

        // single request
        bus.req_data[7:0] = 8'b10110111;
        bus.req = 4'b0001;
        xfer(rr_pick(bus.req, model_last), 8'b10110111, 8'b10101101, 1'b1, 1'b0, 1'b1);

        // round robin with all requests held
        do_reset();
        bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.req = 4'b1111;
        p0 = n_done_pulses;
        for (int i = 0; i < 5; i++) begin
            idx = rr_pick(bus.req, model_last);
            xfer(idx, bus.req_data[idx*W +: W], W'($urandom), 1'b0, 1'b0, 1'b0);
        end
        bus.req = '0;
        repeat (4) @(negedge clk);
        chk("rr_done_count", n_done_pulses - p0, 5);

        // skipping over idle requesters with wrap
        do_reset();
        bus.req_data = W*N'($urandom) ^ {N{8'h5A}};
        bus.req = 4'b0010;
        xfer(rr_pick(bus.req, model_last), bus.req_data[1*W +: W], 8'h3C, 1'b1, 1'b0, 1'b0);
        bus.req = 4'b0011;
        xfer(rr_pick(bus.req, model_last), bus.req_data[0 +: W], 8'hC3, 1'b1, 1'b0, 1'b0);
        xfer(rr_pick(bus.req, model_last), bus.req_data[1*W +: W], 8'h96, 1'b1, 1'b0, 1'b0);

        // reset during WAIT aborts without a done pulse
        do_reset();
        bus.req_data[2*W +: W] = 8'hA7;
        lat_tx = 40;
        lat_rx = 40;
        bus.req = 4'b0100;
        seen = 1'b0;
        for (t = 0; t < 64 && !seen; t++) begin
            @(negedge clk);
            if (bus.gnt != '0) seen = 1'b1;
        end
        chk("abort_gnt", 32'(bus.gnt), 32'h4);
        repeat (5) @(negedge clk);
        p0 = n_done_pulses;
        reset = 1'b0;
        bus.req = '0;
        #1;
        chk("abort_gnt_clear", 32'(bus.gnt), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_m_reset", 32'(bus.m_reset), 0);
        repeat (3) @(negedge clk);
        chk("abort_no_done", n_done_pulses - p0, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        slave_rx_q.delete();
        model_last = N - 1;
        bus.req_data[2*W +: W] = 8'b11111011;
        bus.req = 4'b0100;
        xfer(rr_pick(bus.req, model_last), 8'b11111011, 8'h5E, 1'b1, 1'b0, 1'b0);

        // request dropped and data changed after grant
        do_reset();
        bus.req_data[0 +: W] = 8'hD2;
        bus.req = 4'b0001;
        xfer(rr_pick(bus.req, model_last), 8'hD2, 8'h61, 1'b0, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("no_regrant", 32'(bus.gnt), 0);

        // random request patterns against the reference round robin
        do_reset();
        for (int i = 0; i < 24; i++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            newbits = mask & ~bus.req;
            for (int b = 0; b < N; b++)
                if (newbits[b]) bus.req_data[b*W +: W] = W'($urandom);
            bus.req = bus.req | mask;
            idx = rr_pick(bus.req, model_last);
            xfer(idx, bus.req_data[idx*W +: W], W'($urandom), 1'b1, 1'b0, 1'b0);
        end
        bus.req = '0;

        // watchdog behaviour with tx_done held low
        do_reset();
        bus.req_data = {8'h04, 8'h03, 8'h02, 8'h01};
        force_tx_low = 1'b1;
        bus.req = 4'b0011;
        seen = 1'b0;
        for (t = 0; t < 64 && !seen; t++) begin
            @(negedge clk);
            if (bus.gnt != '0) seen = 1'b1;
        end
        chk("to_gnt", 32'(bus.gnt), 32'h1);
`ifdef SPI_ARB_TIMEOUT_EN
        seen = 1'b0;
        for (t = 0; t < 300 && !seen; t++) begin
            @(negedge clk);
            if (timeout === 1'b1) seen = 1'b1;
        end
        chk("to_latency", t, 66);
        chk("to_done", 32'(bus.done), 32'h1);
        chk("to_rsp", 32'(bus.rsp_data), 32'hFF);
        bus.req[0] = 1'b0;
        force_tx_low = 1'b0;
        slave_rx_q.delete();
        model_last = 0;
        xfer(rr_pick(bus.req, model_last), 8'h02, 8'h77, 1'b1, 1'b0, 1'b0);
        chk("to_pulse_count", n_to_pulses, 1);
`else
        repeat (150) @(negedge clk);
        chk("wait_holds_busy", 32'(busy), 1);
        chk("wait_holds_gnt", 32'(bus.gnt), 32'h1);
        chk("to_pulse_count", n_to_pulses, 0);
        do_reset();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
